// File: rtl/apb4_ram_arbiter_if.sv
// apb4_ram_arbiter_if: N-wide APB4 bundle; master drives the request side, slave answers
interface apb4_ram_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N-1:0]        psel;
  logic [N-1:0]        penable;
  logic [N-1:0]        pwrite;
  logic [N*AW-1:0]     paddr;
  logic [N*DW-1:0]     pwdata;
  logic [N*DW/8-1:0]   pstrb;
  logic [N*3-1:0]      pprot;
  logic [N-1:0]        pready;
  logic [DW-1:0]       prdata;
  logic [N-1:0]        pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, input pready, prdata, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, pstrb, pprot, output pready, prdata, pslverr);
endinterface

// File: rtl/apb4_ram_arbiter.sv
// apb4_ram_arbiter: round-robin sharing of one APB4 completer among N_REQ APB4 requesters
module apb4_ram_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb4_ram_arbiter_if.slave  s,
  apb4_ram_arbiter_if.master m,
  output logic [GW-1:0]     gnt_idx
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] rr_ptr, off, win;
  logic [GW:0] sum;
  logic [N_REQ-1:0] rot, onehot;
  logic done, ok;
  logic cmd_write, sel_write;
  logic [ADDR_WIDTH-1:0] cmd_addr, sel_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata, sel_wdata;
  logic [SW-1:0] cmd_strb, sel_strb;
  logic [2:0] cmd_prot, sel_prot;
  // rotate requests so bit 0 is rr_ptr, take the lowest set bit, rotate back
  always_comb begin
    rot = N_REQ'({s.psel, s.psel} >> rr_ptr);
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = GW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    win = sum >= (GW+1)'(N_REQ) ? GW'(sum - (GW+1)'(N_REQ)) : GW'(sum);
  end
  // select the winning requester's command fields
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win == GW'(i)) begin
        sel_write = s.pwrite[i];
        sel_addr  = s.paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = s.pwdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = s.pstrb[i*SW +: SW];
        sel_prot  = s.pprot[i*3 +: 3];
      end
  end
  // next state, downstream bus and the response routed back to the granted requester only
  always_comb begin
    state_nxt = state == IDLE ? (|s.psel ? SETUP : IDLE) : state == SETUP ? ACCESS : (m.pready[0] ? IDLE : ACCESS);
    done = state == ACCESS && m.pready[0];
    ok = done && s.psel[gnt_idx];
    onehot = N_REQ'(1) << gnt_idx;
    m.psel[0]    = state != IDLE;
    m.penable[0] = state == ACCESS;
    m.pwrite[0]  = cmd_write;
    m.paddr      = cmd_addr;
    m.pwdata     = cmd_wdata;
    m.pstrb      = cmd_strb;
    m.pprot      = cmd_prot;
    s.pready     = ok ? onehot : '0;
    s.pslverr    = ok && m.pslverr[0] ? onehot : '0;
    s.prdata     = ok ? m.prdata : '0;
  end
  // state, grant and command capture; commands are frozen from IDLE until the transfer ends
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_strb  <= '0;
      cmd_prot  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |s.psel) begin
        gnt_idx   <= win;
        cmd_write <= sel_write;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        cmd_strb  <= sel_strb;
        cmd_prot  <= sel_prot;
      end
      if (done) rr_ptr <= gnt_idx == GW'(N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  // a requester may never raise PENABLE without PSEL
  assert property (@(posedge PCLK) disable iff (PRESET) (s.penable & ~s.psel) == '0);
endmodule

// File: tb/tb_apb4_ram_arbiter.sv
// tb_apb4_ram_arbiter: table-driven and hand-sequenced checks of the round-robin APB4 arbiter
module tb_apb4_ram_arbiter;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [0:0] gnt_idx;
  int n_vec = 0, n_bad = 0;
  apb4_ram_arbiter_if #(.N(2), .AW(32), .DW(32)) up ();
  apb4_ram_arbiter_if #(.N(1), .AW(32), .DW(32)) dn ();
  apb4_ram_arbiter #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .s(up), .m(dn), .gnt_idx(gnt_idx));
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic rst; logic [1:0] psel, pen; logic [31:0] a0, a1; logic mrdy; logic [31:0] mrd; logic merr;
    logic e_msel, e_men; logic [31:0] e_maddr; logic e_mwr; logic [1:0] e_rdy, e_err; logic [31:0] e_rd; logic e_gnt;
  } vec_t;
  vec_t v [14];
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask
  task automatic drv(input logic [1:0] ps, input logic [1:0] pe, input logic [31:0] a0, input logic [31:0] a1,
                     input logic rdy, input logic [31:0] rd, input logic err);
    up.psel = ps; up.penable = pe; up.paddr = {a1, a0};
    dn.pready = rdy; dn.prdata = rd; dn.pslverr = err;
  endtask
  initial begin
    up.pwrite = 2'b01;
    up.pwdata = {32'h0, 32'hDEADBEEF};
    up.pstrb  = 8'h0F;
    up.pprot  = {3'b001, 3'b010};
    drv(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    v[0]  = '{1'b0, 2'b01, 2'b00, 32'h10, 32'h0,  1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0, 1'b0};
    v[1]  = '{1'b0, 2'b01, 2'b01, 32'h10, 32'h0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
    v[2]  = '{1'b0, 2'b01, 2'b01, 32'h10, 32'h0,  1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 2'b01, 2'b00, 32'hA5A5A5A5, 1'b0};
    v[3]  = '{1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0, 1'b0};
    v[4]  = '{1'b0, 2'b11, 2'b00, 32'h40, 32'h80, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0, 1'b0};
    v[5]  = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h80, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
    v[6]  = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h80, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 2'b01, 2'b00, 32'h11111111, 1'b0};
    v[7]  = '{1'b0, 2'b10, 2'b10, 32'h40, 32'h80, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
    v[8]  = '{1'b0, 2'b10, 2'b10, 32'h40, 32'h80, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 2'b00, 2'b00, 32'h0, 1'b1};
    v[9]  = '{1'b0, 2'b10, 2'b10, 32'h40, 32'h80, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 2'b10, 2'b00, 32'h22222222, 1'b1};
    v[10] = '{1'b0, 2'b11, 2'b00, 32'h44, 32'h84, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 2'b00, 2'b00, 32'h0, 1'b1};
    v[11] = '{1'b0, 2'b11, 2'b11, 32'h44, 32'h84, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
    v[12] = '{1'b0, 2'b11, 2'b11, 32'h44, 32'h84, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 2'b01, 2'b01, 32'h33333333, 1'b0};
    v[13] = '{1'b0, 2'b00, 2'b00, 32'h44, 32'h84, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h44, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick;
      PRESET = v[i].rst;
      drv(v[i].psel, v[i].pen, v[i].a0, v[i].a1, v[i].mrdy, v[i].mrd, v[i].merr);
      #2;
      chk($sformatf("vec%0d", i),
          {dn.psel, dn.penable, dn.paddr, dn.pwrite, up.pready, up.pslverr, up.prdata, gnt_idx},
          {v[i].e_msel, v[i].e_men, v[i].e_maddr, v[i].e_mwr, v[i].e_rdy, v[i].e_err, v[i].e_rd, v[i].e_gnt});
    end
    // requester 1 read, three wait states, error response: ready exactly in cycle 5
    for (int c = 0; c < 6; c++) begin
      tick;
      drv(2'b10, c == 0 ? 2'b00 : 2'b10, 32'h0, 32'h100, c == 5, 32'h12345678, 1'b1);
      #2;
      chk($sformatf("wait_c%0d", c), {dn.psel, dn.penable, up.pready, up.pslverr, up.prdata, gnt_idx},
          {c > 0, c > 1, c == 5 ? 2'b10 : 2'b00, c == 5 ? 2'b10 : 2'b00, c == 5 ? 32'h12345678 : 32'h0, c > 0});
    end
    // requester 0 write; address changed mid-transfer must not reach the bus
    tick;
    drv(2'b01, 2'b00, 32'h10, 32'h0, 1'b0, 0, 1'b0);
    #2 chk("hold_idle", {dn.psel, dn.penable}, 2'b00);
    tick;
    drv(2'b01, 2'b01, 32'h10, 32'h0, 1'b0, 0, 1'b0);
    #2 chk("hold_setup", {dn.psel, dn.penable, dn.paddr, dn.pwdata, dn.pstrb, dn.pprot, dn.pwrite},
           {1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 1'b1});
    for (int c = 2; c < 5; c++) begin
      tick;
      drv(2'b01, 2'b01, 32'h20, 32'h0, c == 4, 0, 1'b0);
      #2 chk($sformatf("hold_c%0d", c), {dn.penable, dn.paddr, up.pready}, {1'b1, 32'h10, c == 4 ? 2'b01 : 2'b00});
    end
    tick;
    drv(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    // reset pulsed during ACCESS abandons the transfer and clears rr_ptr
    tick;
    drv(2'b01, 2'b00, 32'h30, 32'h0, 1'b0, 0, 1'b0);
    tick;
    drv(2'b01, 2'b01, 32'h30, 32'h0, 1'b0, 0, 1'b0);
    tick;
    #2 chk("rst_access", {dn.psel, dn.penable}, 2'b11);
    #1;
    PRESET = 1'b1;
    dn.pready = 1'b1;
    #1 chk("rst_drop", {dn.psel, dn.penable, up.pready, gnt_idx}, 5'b0);
    tick;
    PRESET = 1'b0;
    drv(2'b11, 2'b00, 32'h50, 32'h90, 1'b0, 0, 1'b0);
    #2 chk("rst_idle", {dn.psel, up.pready}, 3'b0);
    tick;
    drv(2'b11, 2'b11, 32'h50, 32'h90, 1'b0, 0, 1'b0);
    #2 chk("rst_regrant", {dn.psel, dn.penable, dn.paddr, gnt_idx}, {1'b1, 1'b0, 32'h50, 1'b0});
    tick;
    drv(2'b11, 2'b11, 32'h50, 32'h90, 1'b1, 32'h5A5A5A5A, 1'b0);
    #2 chk("rst_done", {up.pready, up.prdata}, {2'b01, 32'h5A5A5A5A});
    tick;
    drv(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    // requester 0 drops PSEL in SETUP: transfer finishes silently, requester 1 served next
    tick;
    drv(2'b01, 2'b00, 32'h60, 32'hA0, 1'b0, 0, 1'b0);
    tick;
    drv(2'b10, 2'b00, 32'h60, 32'hA0, 1'b0, 0, 1'b0);
    #2 chk("drop_setup", {dn.psel, dn.penable, dn.paddr, gnt_idx, up.pready}, {1'b1, 1'b0, 32'h60, 1'b0, 2'b00});
    tick;
    drv(2'b10, 2'b10, 32'h60, 32'hA0, 1'b1, 32'h77777777, 1'b1);
    #2 chk("drop_access", {dn.penable, up.pready, up.pslverr}, {1'b1, 2'b00, 2'b00});
    tick;
    drv(2'b10, 2'b10, 32'h60, 32'hA0, 1'b0, 0, 1'b0);
    #2 chk("drop_idle", {dn.psel, up.pready}, 3'b0);
    tick;
    #2 chk("drop_next", {dn.psel, dn.paddr, gnt_idx}, {1'b1, 32'hA0, 1'b1});
    tick;
    drv(2'b10, 2'b10, 32'h60, 32'hA0, 1'b1, 32'h88888888, 1'b0);
    #2 chk("drop_next_done", {up.pready, up.prdata}, {2'b10, 32'h88888888});
    tick;
    drv(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b0);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
